cache_ctrl_2way: RTL and testbench

- Control FSM for the 2-way set-associative cache. It sits directly upstream of the single-bit PLRU tracker.
- It reads the LRU way to choose a victim on a miss. It drives a PLRU write with the accessed way on every hit.
- It sequences writeback, allocate and re-compare against physical memory, and drives the datapath load/select strobes.

---
 rtl/cache_ctrl_2way.sv | 154 +++++++++++++++
 tb/tb_cache_ctrl_2way.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl_2way.sv
// Control FSM for a 2-way set-associative cache.
// Selects the victim from the PLRU on a miss and updates the PLRU on every hit.
// Sequences writeback, allocate and re-compare against physical memory.
module cache_ctrl_2way #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic       clk0,
    input  logic       rst0,
    input  logic       mem_read,
    input  logic       mem_write,
    input  logic [1:0] hit,
    input  logic [1:0] dirty,
    input  logic       lru_way,
    input  logic       pmem_resp,
    output logic       mem_resp,
    output logic       pmem_read,
    output logic       pmem_write,
    output logic       pmem_addr_sel,
    output logic       plru_csb,
    output logic       plru_web,
    output logic       plru_din,
    output logic       way_sel,
    output logic       load_data,
    output logic       data_src,
    output logic       load_tag,
    output logic       set_valid,
    output logic       set_dirty,
    output logic       clr_dirty,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMPARE   = 2'd1,
        WRITEBACK = 2'd2,
        ALLOCATE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    logic             victim;
    logic [CNT_W-1:0] cnt;
    logic             victim_load;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             err_set;
    logic             req;
    logic             timeout_hit;

    assign req         = mem_read | mem_write;
    assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_LAST);

    // State, victim way, wait counter and sticky error flag.
    always_ff @(posedge clk0 or negedge rst0) begin
        if (!rst0) begin
            state  <= IDLE;
            victim <= 1'b0;
            cnt    <= '0;
            err    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (victim_load) victim <= lru_way;
            if (cnt_clr)
                cnt <= '0;
            else if (cnt_inc)
                cnt <= cnt + 1'b1;
            if (err_set) err <= 1'b1;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_nxt     = state;
        victim_load   = 1'b0;
        cnt_clr       = 1'b0;
        cnt_inc       = 1'b0;
        err_set       = 1'b0;
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        pmem_addr_sel = 1'b0;
        plru_csb      = 1'b1;
        plru_web      = 1'b1;
        plru_din      = 1'b0;
        way_sel       = 1'b0;
        load_data     = 1'b0;
        data_src      = 1'b0;
        load_tag      = 1'b0;
        set_valid     = 1'b0;
        set_dirty     = 1'b0;
        clr_dirty     = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) state_nxt = COMPARE;
            end
            COMPARE: begin
                if (!req) begin
                    state_nxt = IDLE;
                end else if (|hit) begin
                    mem_resp  = 1'b1;
                    plru_csb  = 1'b0;
                    plru_web  = 1'b0;
                    plru_din  = ~hit[0];
                    way_sel   = ~hit[0];
                    if (mem_write) begin
                        load_data = 1'b1;
                        set_dirty = 1'b1;
                    end
                    state_nxt = IDLE;
                end else begin
                    victim_load = 1'b1;
                    cnt_clr     = 1'b1;
                    state_nxt   = dirty[lru_way] ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                pmem_write    = 1'b1;
                pmem_addr_sel = 1'b1;
                way_sel       = victim;
                if (pmem_resp) begin
                    cnt_clr   = 1'b1;
                    state_nxt = ALLOCATE;
                end else if (timeout_hit) begin
                    err_set   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ALLOCATE: begin
                pmem_read = 1'b1;
                way_sel   = victim;
                if (pmem_resp) begin
                    load_data = 1'b1;
                    data_src  = 1'b1;
                    load_tag  = 1'b1;
                    set_valid = 1'b1;
                    clr_dirty = 1'b1;
                    state_nxt = COMPARE;
                end else if (timeout_hit) begin
                    err_set   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_ctrl_2way.sv
// Testbench for cache_ctrl_2way: per-cycle vector table with a scoreboard
// queue, plus hand-written timeout and asynchronous-reset sequences.
module tb_cache_ctrl_2way;

    logic       clk0;
    logic       rst0;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] hit;
    logic [1:0] dirty;
    logic       lru_way;
    logic       pmem_resp;
    logic       mem_resp;
    logic       pmem_read;
    logic       pmem_write;
    logic       pmem_addr_sel;
    logic       plru_csb;
    logic       plru_web;
    logic       plru_din;
    logic       way_sel;
    logic       load_data;
    logic       data_src;
    logic       load_tag;
    logic       set_valid;
    logic       set_dirty;
    logic       clr_dirty;
    logic       err;

    cache_ctrl_2way #(
        .TIMEOUT(4),
        .CNT_W  (8)
    ) dut (
        .clk0         (clk0),
        .rst0         (rst0),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .hit          (hit),
        .dirty        (dirty),
        .lru_way      (lru_way),
        .pmem_resp    (pmem_resp),
        .mem_resp     (mem_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_addr_sel(pmem_addr_sel),
        .plru_csb     (plru_csb),
        .plru_web     (plru_web),
        .plru_din     (plru_din),
        .way_sel      (way_sel),
        .load_data    (load_data),
        .data_src     (data_src),
        .load_tag     (load_tag),
        .set_valid    (set_valid),
        .set_dirty    (set_dirty),
        .clr_dirty    (clr_dirty),
        .err          (err)
    );

    // Output bit order:
    // resp pr pw asel csb web din way ld src tag val sd cd err
    logic [14:0] outs;
    assign outs = {mem_resp, pmem_read, pmem_write, pmem_addr_sel, plru_csb,
                   plru_web, plru_din, way_sel, load_data, data_src, load_tag,
                   set_valid, set_dirty, clr_dirty, err};

    localparam logic [14:0] O_IDLE  = 15'b0_0_0_0_1_1_0_0_0_0_0_0_0_0_0;
    localparam logic [14:0] O_IDLEE = 15'b0_0_0_0_1_1_0_0_0_0_0_0_0_0_1;
    localparam logic [14:0] O_RH1   = 15'b1_0_0_0_0_0_1_1_0_0_0_0_0_0_0;
    localparam logic [14:0] O_RH0   = 15'b1_0_0_0_0_0_0_0_0_0_0_0_0_0_0;
    localparam logic [14:0] O_RH0E  = 15'b1_0_0_0_0_0_0_0_0_0_0_0_0_0_1;
    localparam logic [14:0] O_WH0   = 15'b1_0_0_0_0_0_0_0_1_0_0_0_1_0_0;
    localparam logic [14:0] O_WH1   = 15'b1_0_0_0_0_0_1_1_1_0_0_0_1_0_0;
    localparam logic [14:0] O_AL1   = 15'b0_1_0_0_1_1_0_1_0_0_0_0_0_0_0;
    localparam logic [14:0] O_AL1E  = 15'b0_1_0_0_1_1_0_1_0_0_0_0_0_0_1;
    localparam logic [14:0] O_AL0   = 15'b0_1_0_0_1_1_0_0_0_0_0_0_0_0_0;
    localparam logic [14:0] O_FL1   = 15'b0_1_0_0_1_1_0_1_1_1_1_1_0_1_0;
    localparam logic [14:0] O_FL0   = 15'b0_1_0_0_1_1_0_0_1_1_1_1_0_1_0;
    localparam logic [14:0] O_WB0   = 15'b0_0_1_1_1_1_0_0_0_0_0_0_0_0_0;

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [1:0]  hit;
        logic [1:0]  dirty;
        logic        lru;
        logic        presp;
        logic [14:0] exp;
    } vec_t;

    typedef struct {
        string       name;
        logic [14:0] exp;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb_q[$];
    int   checks;
    int   fails;

    function automatic vec_t mk(input string name, input logic rd, input logic wr,
                                input logic [1:0] h, input logic [1:0] d,
                                input logic lru, input logic presp,
                                input logic [14:0] exp);
        vec_t v;
        v.name  = name;
        v.rd    = rd;
        v.wr    = wr;
        v.hit   = h;
        v.dirty = d;
        v.lru   = lru;
        v.presp = presp;
        v.exp   = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [14:0] got, input logic [14:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    // One cycle: drive at posedge+1, push expectation, compare at negedge.
    task automatic apply(input vec_t v);
        sb_t e;
        mem_read  = v.rd;
        mem_write = v.wr;
        hit       = v.hit;
        dirty     = v.dirty;
        lru_way   = v.lru;
        pmem_resp = v.presp;
        e.name    = v.name;
        e.exp     = v.exp;
        sb_q.push_back(e);
        @(negedge clk0);
        e = sb_q.pop_front();
        check(e.name, outs, e.exp);
        @(posedge clk0);
        #1;
    endtask

    initial begin
        clk0 = 1'b0;
        forever #5 clk0 = ~clk0;
    end

    initial begin
        checks    = 0;
        fails     = 0;
        rst0      = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        hit       = 2'b00;
        dirty     = 2'b00;
        lru_way   = 1'b0;
        pmem_resp = 1'b0;

        // name, rd, wr, hit, dirty, lru, presp, expected outputs
        vecs.push_back(mk("rh_c0", 1, 0, 2'b10, 2'b00, 0, 0, O_IDLE));
        vecs.push_back(mk("rh_c1", 1, 0, 2'b10, 2'b00, 0, 0, O_RH1));
        vecs.push_back(mk("rh_c2", 0, 0, 2'b00, 2'b00, 0, 0, O_IDLE));
        vecs.push_back(mk("wh_c0", 0, 1, 2'b01, 2'b00, 1, 0, O_IDLE));
        vecs.push_back(mk("wh_c1", 0, 1, 2'b01, 2'b00, 1, 0, O_WH0));
        vecs.push_back(mk("wh_c2", 0, 0, 2'b00, 2'b00, 0, 0, O_IDLE));
        vecs.push_back(mk("both_c0", 1, 1, 2'b11, 2'b00, 1, 0, O_IDLE));
        vecs.push_back(mk("both_c1", 1, 1, 2'b11, 2'b00, 1, 0, O_WH0));
        vecs.push_back(mk("rw10_c0", 1, 1, 2'b10, 2'b00, 0, 0, O_IDLE));
        vecs.push_back(mk("rw10_c1", 1, 1, 2'b10, 2'b00, 0, 0, O_WH1));
        vecs.push_back(mk("cm_c0", 1, 0, 2'b00, 2'b00, 1, 0, O_IDLE));
        vecs.push_back(mk("cm_c1", 1, 0, 2'b00, 2'b00, 1, 0, O_IDLE));
        vecs.push_back(mk("cm_c2", 1, 0, 2'b00, 2'b00, 0, 0, O_AL1));
        vecs.push_back(mk("cm_c3", 1, 0, 2'b00, 2'b00, 0, 0, O_AL1));
        vecs.push_back(mk("cm_c4", 1, 0, 2'b10, 2'b00, 0, 1, O_FL1));
        vecs.push_back(mk("cm_c5", 1, 0, 2'b10, 2'b00, 0, 0, O_RH1));
        vecs.push_back(mk("cm_c6", 0, 0, 2'b00, 2'b00, 0, 0, O_IDLE));
        vecs.push_back(mk("dm_c0", 1, 0, 2'b00, 2'b01, 0, 0, O_IDLE));
        vecs.push_back(mk("dm_c1", 1, 0, 2'b00, 2'b01, 0, 0, O_IDLE));
        vecs.push_back(mk("dm_c2", 1, 0, 2'b00, 2'b01, 1, 0, O_WB0));
        vecs.push_back(mk("dm_c3", 1, 0, 2'b00, 2'b01, 1, 1, O_WB0));
        vecs.push_back(mk("dm_c4", 1, 0, 2'b00, 2'b00, 1, 0, O_AL0));
        vecs.push_back(mk("dm_c5", 1, 0, 2'b01, 2'b00, 1, 1, O_FL0));
        vecs.push_back(mk("dm_c6", 1, 0, 2'b01, 2'b00, 1, 0, O_RH0));
        vecs.push_back(mk("dm_c7", 0, 0, 2'b00, 2'b00, 0, 0, O_IDLE));
        vecs.push_back(mk("drop_c0", 1, 0, 2'b00, 2'b00, 0, 0, O_IDLE));
        vecs.push_back(mk("drop_c1", 1, 0, 2'b00, 2'b00, 0, 0, O_IDLE));
        vecs.push_back(mk("drop_c2", 0, 0, 2'b00, 2'b00, 1, 0, O_AL0));
        vecs.push_back(mk("drop_c3", 0, 0, 2'b00, 2'b00, 1, 1, O_FL0));
        vecs.push_back(mk("drop_c4", 0, 0, 2'b01, 2'b00, 1, 0, O_IDLE));
        vecs.push_back(mk("stray_c5", 0, 0, 2'b00, 2'b00, 0, 1, O_IDLE));
        vecs.push_back(mk("stray_c6", 0, 0, 2'b00, 2'b00, 0, 0, O_IDLE));

        #3;
        check("reset_state", outs, O_IDLE);
        #5 rst0 = 1'b1;
        @(posedge clk0);
        #1;

        foreach (vecs[i]) apply(vecs[i]);

        // Timeout during ALLOCATE: four cycles of pmem_read, then sticky err.
        apply(mk("to_c0", 1, 0, 2'b00, 2'b00, 1, 0, O_IDLE));
        apply(mk("to_c1", 1, 0, 2'b00, 2'b00, 1, 0, O_IDLE));
        apply(mk("to_c2", 1, 0, 2'b00, 2'b00, 1, 0, O_AL1));
        apply(mk("to_c3", 1, 0, 2'b00, 2'b00, 1, 0, O_AL1));
        apply(mk("to_c4", 1, 0, 2'b00, 2'b00, 1, 0, O_AL1));
        apply(mk("to_c5", 1, 0, 2'b00, 2'b00, 1, 0, O_AL1));
        apply(mk("to_c6", 0, 0, 2'b00, 2'b00, 1, 0, O_IDLEE));
        apply(mk("to_c7", 1, 0, 2'b01, 2'b00, 1, 0, O_IDLEE));
        apply(mk("to_c8", 1, 0, 2'b01, 2'b00, 1, 0, O_RH0E));
        apply(mk("to_c9", 0, 0, 2'b00, 2'b00, 0, 0, O_IDLEE));

        // Asynchronous reset in the middle of ALLOCATE, away from any edge.
        apply(mk("ar_c0", 1, 0, 2'b00, 2'b00, 1, 0, O_IDLEE));
        apply(mk("ar_c1", 1, 0, 2'b00, 2'b00, 1, 0, O_IDLEE));
        apply(mk("ar_c2", 1, 0, 2'b00, 2'b00, 1, 0, O_AL1E));
        rst0 = 1'b0;
        #1;
        check("async_reset", outs, O_IDLE);
        mem_read = 1'b0;
        @(posedge clk0);
        @(negedge clk0);
        rst0 = 1'b1;
        @(posedge clk0);
        #1;
        apply(mk("pr_c0", 1, 0, 2'b10, 2'b00, 0, 0, O_IDLE));
        apply(mk("pr_c1", 1, 0, 2'b10, 2'b00, 0, 0, O_RH1));
        apply(mk("pr_c2", 0, 0, 2'b00, 2'b00, 0, 0, O_IDLE));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
